ring_token_sched: RTL

RING_TOKEN_SCHED -- requirements
Module: ring_token_sched

---
 rtl/ring_token_sched_if.sv | 26 ++
 rtl/ring_token_sched.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/ring_token_sched_if.sv
// Purpose: request/grant bundle between ring nodes and the token scheduler.
// Latency: none, wires only.
// Backpressure: none; req is a level, and grant is the only response to it.
interface ring_token_sched_if #(
    parameter int K = 8
);
    logic [K-1:0] req;
    logic         loss;
    logic [K-1:0] grant;
    logic [5:0]   token_pos;
    logic         stable;
    logic         lost;
    logic         lap_done;

    // Node/environment side: drives requests and the loss indication
    modport master (
        output req, loss,
        input  grant, token_pos, stable, lost, lap_done
    );

    // Scheduler side
    modport slave (
        input  req, loss,
        output grant, token_pos, stable, lost, lap_done
    );
endinterface

// File: rtl/ring_token_sched.sv
// Purpose: token-ring arbiter granting one node at a time, with token-loss detection and optional regeneration.
// Latency: grant is registered, so it rises one cycle after the token reaches a requesting node.
// Backpressure: none; a holder keeps grant for at most HOLD_MAX cycles, then the token moves on.
// Build option: define RING_TOKEN_REGEN_EN to regenerate a lost token at node 0 after TIMEOUT cycles.
module ring_token_sched #(
    parameter int K        = 8,
    parameter int HOLD_MAX = 4,
    parameter int TIMEOUT  = 16
) (
    input  logic               clk,
    input  logic               reset,
    ring_token_sched_if.slave  bus
);
    if (K < 2 || K > 64 || HOLD_MAX < 1 || HOLD_MAX > 255 ||
        TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_param
        $error("ring_token_sched: parameter out of range");
    end

    typedef enum logic [1:0] {CIRCULATE, HOLD, LOST} state_t;

    localparam logic [5:0] POS_LAST = 6'(K - 1);
    localparam logic [7:0] HOLD_LIM = 8'(HOLD_MAX);

    state_t       state_q, state_d;
    logic [5:0]   pos_q, pos_d;
    logic [5:0]   hop_q, hop_d;
    logic [7:0]   hold_q, hold_d;
    logic [K-1:0] grant_q, grant_d;
    logic         stable_q, stable_d;
    logic         lap_q, lap_d;
    logic         do_pass;
    logic [K-1:0] pos_oh;
    logic         req_here;
`ifdef RING_TOKEN_REGEN_EN
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);
    logic [7:0]   tmo_q, tmo_d;
`endif

    // One-hot of the holder position; avoids a narrow-index select into req
    assign pos_oh   = {{(K-1){1'b0}}, 1'b1} << pos_q;
    assign req_here = |(bus.req & pos_oh);

    // Next-state and output decode; a pass is requested here and resolved after the case
    always_comb begin
        state_d  = state_q;
        pos_d    = pos_q;
        hop_d    = hop_q;
        hold_d   = hold_q;
        grant_d  = '0;
        stable_d = stable_q;
        lap_d    = 1'b0;
        do_pass  = 1'b0;
`ifdef RING_TOKEN_REGEN_EN
        tmo_d    = tmo_q;
`endif
        case (state_q)
            CIRCULATE: begin
                // Capturing the token takes priority over loss on this hop
                if (req_here) begin
                    state_d = HOLD;
                    grant_d = pos_oh;
                    hold_d  = 8'd1;
                end else begin
                    do_pass = 1'b1;
                end
            end
            HOLD: begin
                if (req_here && hold_q < HOLD_LIM) begin
                    grant_d = pos_oh;
                    hold_d  = hold_q + 8'd1;
                end else begin
                    // Exit always hands the token on in the same cycle, so a node cut off
                    // at HOLD_MAX cannot see it again until the ring has gone round.
                    state_d = CIRCULATE;
                    do_pass = 1'b1;
                end
            end
            LOST: begin
`ifdef RING_TOKEN_REGEN_EN
                if (tmo_q == TMO_LAST) begin
                    state_d = CIRCULATE;
                    pos_d   = '0;
                    hop_d   = '0;
                    tmo_d   = '0;
                end else begin
                    tmo_d   = tmo_q + 8'd1;
                end
`endif
            end
            default: state_d = CIRCULATE;
        endcase

        if (do_pass) begin
            if (bus.loss) begin
                state_d  = LOST;
                hop_d    = '0;
                stable_d = 1'b0;
`ifdef RING_TOKEN_REGEN_EN
                tmo_d    = '0;
`endif
            end else begin
                pos_d = (pos_q == POS_LAST) ? 6'd0 : pos_q + 6'd1;
                hop_d = (hop_q == POS_LAST) ? hop_q : hop_q + 6'd1;
                if (hop_d == POS_LAST) begin
                    stable_d = 1'b1;
                end
                lap_d = (pos_q == POS_LAST);
            end
        end
    end

    // State and output registers, cleared asynchronously
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= CIRCULATE;
            pos_q    <= '0;
            hop_q    <= '0;
            hold_q   <= '0;
            grant_q  <= '0;
            stable_q <= 1'b0;
            lap_q    <= 1'b0;
`ifdef RING_TOKEN_REGEN_EN
            tmo_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            pos_q    <= pos_d;
            hop_q    <= hop_d;
            hold_q   <= hold_d;
            grant_q  <= grant_d;
            stable_q <= stable_d;
            lap_q    <= lap_d;
`ifdef RING_TOKEN_REGEN_EN
            tmo_q    <= tmo_d;
`endif
        end
    end

    assign bus.grant     = grant_q;
    assign bus.token_pos = pos_q;
    assign bus.stable    = stable_q;
    assign bus.lost      = (state_q == LOST);
    assign bus.lap_done  = lap_q;
endmodule
